// File: rtl/sc_ifu_if.sv
// Instruction-memory fetch bus between sc_ifu (master) and the instruction memory (slave).
interface sc_ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rdy, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rdy, imem_rdata);
endinterface

// File: rtl/sc_ifu.sv
// Single-cycle-style instruction fetch unit: FETCH/ISSUE handshake with next-PC selection.
// Optional misaligned-target trap enabled by macro SC_IFU_ALIGN_CHECK_EN.
module sc_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          ERR_STICKY = 1'b1
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [1:0]      pcsource,
  input  logic [31:0]     ra,
  input  logic            exec_done,
  sc_ifu_if.master        imem,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [5:0]      op,
  output logic [5:0]      func,
  output logic [31:0]     pc,
  output logic [31:0]     pc4,
  output logic            misalign
);

`ifdef SC_IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH = 2'b00, ISSUE = 2'b01, ERR = 2'b10} state_e;
`else
  typedef enum logic [1:0] {FETCH = 2'b00, ISSUE = 2'b01} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] pc4_s, branch_s, jump_s, raw_pc_s, next_pc_s;
  logic        align_err_s;

  assign pc4_s    = pc_q + 32'd4;
  assign branch_s = pc4_s + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign jump_s   = {pc4_s[31:28], inst_q[25:0], 2'b00};

  // Next-PC candidate selected by the control unit
  always_comb begin
    raw_pc_s = pc4_s;
    case (pcsource)
      2'b00:   raw_pc_s = pc4_s;
      2'b01:   raw_pc_s = branch_s;
      2'b10:   raw_pc_s = ra;
      2'b11:   raw_pc_s = jump_s;
      default: raw_pc_s = pc4_s;
    endcase
  end

`ifdef SC_IFU_ALIGN_CHECK_EN
  assign next_pc_s   = raw_pc_s;
  assign align_err_s = |raw_pc_s[1:0];
`else
  assign next_pc_s   = raw_pc_s & 32'hFFFF_FFFC;
  assign align_err_s = 1'b0;
`endif

  // FSM next state, PC update and instruction capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    case (state_q)
      // req_q gates acceptance so nothing is captured before the first request is issued
      FETCH: begin
        if (req_q && imem.imem_rdy) begin
          inst_d  = imem.imem_rdata;
          state_d = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          if (align_err_s) begin
`ifdef SC_IFU_ALIGN_CHECK_EN
            state_d = ERR;
`else
            state_d = FETCH;
`endif
          end else begin
            pc_d    = next_pc_s;
            state_d = FETCH;
          end
        end else begin
          state_d = ISSUE;
        end
      end
`ifdef SC_IFU_ALIGN_CHECK_EN
      ERR: begin
        if (ERR_STICKY) begin
          state_d = ERR;
        end else begin
          state_d = FETCH;
        end
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  assign req_d   = (state_d == FETCH);
  assign valid_d = (state_d == ISSUE);

  // State, PC, instruction and registered handshake outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      req_q   <= req_d;
      valid_q <= valid_d;
    end
  end

`ifdef SC_IFU_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign misalign_d = (state_d == ERR);

  // Registered misalign flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = valid_q;
  assign op             = inst_q[31:26];
  assign func           = inst_q[5:0];
  assign pc             = pc_q;
  assign pc4            = pc4_s;

endmodule
